// File: rtl/rx_sym_collect.sv
// Collects subcarriers 0..N_SC-1 of one OFDM symbol from the serial-to-parallel
// stage, publishes the snapshot with QPSK decisions and erasures, and flags faults.
module rx_sym_collect #(
  parameter int N_SC     = 8,
  parameter int DW       = 20,
  parameter int TIMEOUT  = 64,
  parameter int ERASE_TH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SC*DW-1:0]   receive_sig_real,
  input  logic [N_SC*DW-1:0]   receive_sig_imag,
  input  logic [N_SC-1:0]      Rx_tvalid,
  output logic [N_SC*DW-1:0]   sym_real,
  output logic [N_SC*DW-1:0]   sym_imag,
  output logic [2*N_SC-1:0]    sym_bits,
  output logic [N_SC-1:0]      sym_erase,
  output logic                 sym_valid,
  output logic                 sym_err,
  output logic [1:0]           err_code,
  output logic [15:0]          frame_cnt,
  output logic [7:0]           err_cnt
);

  localparam int IW = (N_SC > 1) ? $clog2(N_SC) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW:0] L_ERASE_TH = (DW+1)'(ERASE_TH);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t               r_state;
  logic [IW-1:0]        r_expect;
  logic [TW-1:0]        r_timer;
  logic [N_SC*DW-1:0]   r_sh_real;
  logic [N_SC*DW-1:0]   r_sh_imag;
  logic [N_SC*DW-1:0]   r_sym_real;
  logic [N_SC*DW-1:0]   r_sym_imag;
  logic [2*N_SC-1:0]    r_sym_bits;
  logic [N_SC-1:0]      r_sym_erase;
  logic                 r_sym_valid;
  logic                 r_sym_err;
  logic [1:0]           r_err_code;
  logic [15:0]          r_frame_cnt;
  logic [7:0]           r_err_cnt;

  logic                 w_any;
  logic                 w_legal;
  logic [IW-1:0]        w_idx;
  logic                 w_beat0;
  logic                 w_hit;
  logic                 w_done;
  logic                 w_restart;
  logic                 w_bad;
  logic                 w_tmo;
  logic                 w_fault;
  logic [1:0]           w_code;
  logic                 w_capture;
  logic [N_SC*DW-1:0]   w_full_real;
  logic [N_SC*DW-1:0]   w_full_imag;
  logic [2*N_SC-1:0]    w_bits;
  logic [N_SC-1:0]      w_erase;

  // Magnitude is taken one bit wider so the most negative sample does not alias to itself.
  function automatic logic is_erase(input logic [DW-1:0] x);
    logic [DW:0] ext;
    logic [DW:0] mag;
    ext = {x[DW-1], x};
    mag = x[DW-1] ? (~ext + {{DW{1'b0}}, 1'b1}) : ext;
    return (mag < L_ERASE_TH);
  endfunction

  // Beat classification and index encode
  always_comb begin
    w_any   = |Rx_tvalid;
    w_legal = ($countones(Rx_tvalid) == 1);
    w_idx   = '0;
    for (int k = 0; k < N_SC; k++) begin
      w_idx = Rx_tvalid[k] ? IW'(k) : w_idx;
    end
  end

  // Event decode for the current cycle
  always_comb begin
    w_beat0   = w_legal && (w_idx == '0);
    w_hit     = (r_state == S_COLLECT) && w_legal && (w_idx == r_expect);
    w_done    = w_hit && (r_expect == IW'(N_SC-1));
    w_restart = (r_state == S_COLLECT) && w_beat0;
    w_bad     = w_any && !w_beat0 && !w_hit;
    w_tmo     = (r_state == S_COLLECT) && !w_any && (r_timer == TW'(TIMEOUT-2));
    w_fault   = w_bad || w_restart || w_tmo;
    w_capture = w_beat0 || w_hit;
    if (w_bad) begin
      w_code = 2'd1;
    end else if (w_tmo) begin
      w_code = 2'd2;
    end else begin
      w_code = 2'd3;
    end
  end

  // The final slot bypasses the shadow so the symbol is published one cycle after its last beat
  always_comb begin
    w_full_real = {receive_sig_real[N_SC*DW-1 -: DW], r_sh_real[(N_SC-1)*DW-1:0]};
    w_full_imag = {receive_sig_imag[N_SC*DW-1 -: DW], r_sh_imag[(N_SC-1)*DW-1:0]};
    w_bits      = '0;
    w_erase     = '0;
    for (int k = 0; k < N_SC; k++) begin
      w_bits[2*k]   = w_full_real[k*DW + DW - 1];
      w_bits[2*k+1] = w_full_imag[k*DW + DW - 1];
      w_erase[k]    = is_erase(w_full_real[k*DW +: DW]) | is_erase(w_full_imag[k*DW +: DW]);
    end
  end

  // Collection state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_expect <= '0;
      r_timer  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_beat0) begin
            r_state  <= S_COLLECT;
            r_expect <= IW'(1);
            r_timer  <= '0;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_COLLECT: begin
          if (w_done || w_bad || w_tmo) begin
            r_state  <= S_IDLE;
            r_expect <= '0;
            r_timer  <= '0;
          end else if (w_restart) begin
            r_expect <= IW'(1);
            r_timer  <= '0;
          end else if (w_hit) begin
            r_expect <= r_expect + IW'(1);
            r_timer  <= '0;
          end else begin
            r_timer  <= r_timer + TW'(1);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_expect <= '0;
          r_timer  <= '0;
        end
      endcase
    end
  end

  // Shadow buffer capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_real <= '0;
      r_sh_imag <= '0;
    end else if (w_capture) begin
      r_sh_real[w_idx*DW +: DW] <= receive_sig_real[w_idx*DW +: DW];
      r_sh_imag[w_idx*DW +: DW] <= receive_sig_imag[w_idx*DW +: DW];
    end
  end

  // Symbol outputs and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sym_real  <= '0;
      r_sym_imag  <= '0;
      r_sym_bits  <= '0;
      r_sym_erase <= '0;
      r_sym_valid <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_sym_valid <= w_done;
      if (w_done) begin
        r_sym_real  <= w_full_real;
        r_sym_imag  <= w_full_imag;
        r_sym_bits  <= w_bits;
        r_sym_erase <= w_erase;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // Fault reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sym_err  <= 1'b0;
      r_err_code <= 2'd0;
      r_err_cnt  <= 8'd0;
    end else begin
      r_sym_err <= w_fault;
      if (w_fault) begin
        r_err_code <= w_code;
        if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end
    end
  end

  assign sym_real  = r_sym_real;
  assign sym_imag  = r_sym_imag;
  assign sym_bits  = r_sym_bits;
  assign sym_erase = r_sym_erase;
  assign sym_valid = r_sym_valid;
  assign sym_err   = r_sym_err;
  assign err_code  = r_err_code;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_rx_sym_collect.sv
// Directed bench for rx_sym_collect: complete symbols, gaps, ordering faults,
// timeout, restart, back-to-back symbols and mid-symbol reset.
module tb_rx_sym_collect;

  localparam int N  = 8;
  localparam int DW = 20;

  logic              clk;
  logic              rst;
  logic [N*DW-1:0]   receive_sig_real;
  logic [N*DW-1:0]   receive_sig_imag;
  logic [N-1:0]      Rx_tvalid;
  logic [N*DW-1:0]   sym_real;
  logic [N*DW-1:0]   sym_imag;
  logic [2*N-1:0]    sym_bits;
  logic [N-1:0]      sym_erase;
  logic              sym_valid;
  logic              sym_err;
  logic [1:0]        err_code;
  logic [15:0]       frame_cnt;
  logic [7:0]        err_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int nv     = 0;
  int ne     = 0;
  int v_cyc [64];
  int nv0, ne0;

  logic signed [DW-1:0] exp_re [N];
  logic signed [DW-1:0] exp_im [N];

  rx_sym_collect dut (
    .clk(clk), .rst(rst),
    .receive_sig_real(receive_sig_real), .receive_sig_imag(receive_sig_imag),
    .Rx_tvalid(Rx_tvalid),
    .sym_real(sym_real), .sym_imag(sym_imag), .sym_bits(sym_bits), .sym_erase(sym_erase),
    .sym_valid(sym_valid), .sym_err(sym_err), .err_code(err_code),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (sym_valid) begin
      v_cyc[nv % 64] = cyc;
      nv = nv + 1;
    end
    if (sym_err) ne = ne + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    Rx_tvalid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic beat(input int k, input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
    receive_sig_real = {N{20'sd7}};
    receive_sig_imag = {N{20'sd7}};
    receive_sig_real[k*DW +: DW] = re;
    receive_sig_imag[k*DW +: DW] = im;
    Rx_tvalid = '0;
    Rx_tvalid[k] = 1'b1;
    tick();
    Rx_tvalid = '0;
  endtask

  task automatic idle(input int n);
    Rx_tvalid = '0;
    repeat (n) tick();
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) beat(k, exp_re[k], exp_im[k]);
  endtask

  task automatic fill_base();
    for (int k = 0; k < N; k++) begin
      exp_re[k] = 20'(2000 * (k + 1));
      exp_im[k] = -20'sd3000;
    end
  endtask

  task automatic check_sym(input string tag);
    logic [2*N-1:0] eb;
    logic [N-1:0]   ee;
    int v, w;
    eb = '0;
    ee = '0;
    for (int k = 0; k < N; k++) begin
      v = int'(exp_re[k]);
      w = int'(exp_im[k]);
      eb[2*k]   = (v < 0);
      eb[2*k+1] = (w < 0);
      ee[k]     = (v > -1024 && v < 1024) || (w > -1024 && w < 1024);
      chk({tag, "_re"}, {44'd0, sym_real[k*DW +: DW]}, {44'd0, exp_re[k]});
      chk({tag, "_im"}, {44'd0, sym_imag[k*DW +: DW]}, {44'd0, exp_im[k]});
    end
    chk({tag, "_bits_model"}, {48'd0, sym_bits}, {48'd0, eb});
    chk({tag, "_erase_model"}, {56'd0, sym_erase}, {56'd0, ee});
  endtask

  initial begin
    rst = 1'b0;
    Rx_tvalid = '0;
    receive_sig_real = '0;
    receive_sig_imag = '0;
    do_reset();

    // Reset state
    chk("rst_valid", {63'd0, sym_valid}, 64'd0);
    chk("rst_err", {63'd0, sym_err}, 64'd0);
    chk("rst_bits", {48'd0, sym_bits}, 64'd0);
    chk("rst_real", {44'd0, sym_real[DW-1:0]}, 64'd0);
    chk("rst_frame", {48'd0, frame_cnt}, 64'd0);
    chk("rst_errcnt", {56'd0, err_cnt}, 64'd0);
    chk("rst_code", {62'd0, err_code}, 64'd0);

    // Scenario 1: clean symbol
    fill_base();
    nv0 = nv; ne0 = ne;
    send_range(0, 6);
    chk("s1_novalid_early", {63'd0, sym_valid}, 64'd0);
    send_range(7, 7);
    chk("s1_valid", {63'd0, sym_valid}, 64'd1);
    chk("s1_bits", {48'd0, sym_bits}, 64'hAAAA);
    chk("s1_erase", {56'd0, sym_erase}, 64'h00);
    chk("s1_frame", {48'd0, frame_cnt}, 64'd1);
    check_sym("s1");
    tick();
    chk("s1_valid_pulse", {63'd0, sym_valid}, 64'd0);
    chk("s1_npulse", 64'(nv - nv0), 64'd1);
    chk("s1_noerr", 64'(ne - ne0), 64'd0);

    // Scenario 3: out-of-order beat, outputs from scenario 1 must hold
    nv0 = nv; ne0 = ne;
    beat(0, 20'sd111, 20'sd222);
    beat(1, 20'sd333, 20'sd444);
    beat(3, 20'sd555, 20'sd666);
    chk("s3_err", {63'd0, sym_err}, 64'd1);
    chk("s3_code", {62'd0, err_code}, 64'd1);
    chk("s3_errcnt", {56'd0, err_cnt}, 64'd1);
    idle(2);
    chk("s3_err_pulse", {63'd0, sym_err}, 64'd0);
    chk("s3_code_hold", {62'd0, err_code}, 64'd1);
    chk("s3_novalid", 64'(nv - nv0), 64'd0);
    chk("s3_frame", {48'd0, frame_cnt}, 64'd1);
    chk("s3_bits", {48'd0, sym_bits}, 64'hAAAA);
    check_sym("s3");

    // Scenario 2: gap inside symbol, erasure on slot 5
    do_reset();
    fill_base();
    exp_re[5] = 20'sd500;
    exp_im[5] = -20'sd524288;
    nv0 = nv; ne0 = ne;
    send_range(0, 2);
    idle(3);
    send_range(3, 7);
    chk("s2_valid", {63'd0, sym_valid}, 64'd1);
    chk("s2_erase", {56'd0, sym_erase}, 64'h20);
    chk("s2_bits", {48'd0, sym_bits}, 64'hAAAA);
    check_sym("s2");
    tick();
    chk("s2_npulse", 64'(nv - nv0), 64'd1);
    chk("s2_noerr", 64'(ne - ne0), 64'd0);
    chk("s2_errcnt", {56'd0, err_cnt}, 64'd0);

    // Scenario 4: timeout on the 63rd idle cycle, then recovery
    do_reset();
    fill_base();
    nv0 = nv; ne0 = ne;
    beat(0, exp_re[0], exp_im[0]);
    idle(62);
    chk("s4_no_tmo_early", 64'(ne - ne0), 64'd0);
    chk("s4_err_early", {63'd0, sym_err}, 64'd0);
    idle(1);
    chk("s4_err", {63'd0, sym_err}, 64'd1);
    chk("s4_code", {62'd0, err_code}, 64'd2);
    chk("s4_errcnt", {56'd0, err_cnt}, 64'd1);
    idle(1);
    send_range(0, 7);
    chk("s4_valid", {63'd0, sym_valid}, 64'd1);
    chk("s4_frame", {48'd0, frame_cnt}, 64'd1);
    chk("s4_errcnt_after", {56'd0, err_cnt}, 64'd1);
    check_sym("s4");

    // Scenario 5: restart on a second beat 0
    do_reset();
    fill_base();
    nv0 = nv;
    beat(0, 20'sd9, 20'sd9);
    beat(1, 20'sd9, 20'sd9);
    beat(2, 20'sd9, 20'sd9);
    beat(0, exp_re[0], exp_im[0]);
    chk("s5_err", {63'd0, sym_err}, 64'd1);
    chk("s5_code", {62'd0, err_code}, 64'd3);
    send_range(1, 7);
    chk("s5_valid", {63'd0, sym_valid}, 64'd1);
    chk("s5_errcnt", {56'd0, err_cnt}, 64'd1);
    chk("s5_frame", {48'd0, frame_cnt}, 64'd1);
    check_sym("s5");
    tick();
    chk("s5_npulse", 64'(nv - nv0), 64'd1);

    // Scenario 6: back-to-back symbols, then reset mid-symbol
    do_reset();
    nv0 = nv; ne0 = ne;
    fill_base();
    send_range(0, 7);
    chk("s6_valid_a", {63'd0, sym_valid}, 64'd1);
    check_sym("s6a");
    for (int k = 0; k < N; k++) begin
      exp_re[k] = -20'(1500 * (k + 1));
      exp_im[k] = 20'(4000 + 100 * k);
    end
    send_range(0, 7);
    chk("s6_valid_b", {63'd0, sym_valid}, 64'd1);
    chk("s6_bits_b", {48'd0, sym_bits}, 64'h5555);
    chk("s6_frame", {48'd0, frame_cnt}, 64'd2);
    check_sym("s6b");
    tick();
    chk("s6_npulse", 64'(nv - nv0), 64'd2);
    chk("s6_gap", 64'(v_cyc[(nv0 + 1) % 64] - v_cyc[nv0 % 64]), 64'd8);
    chk("s6_noerr", 64'(ne - ne0), 64'd0);

    do_reset();
    nv0 = nv; ne0 = ne;
    send_range(0, 3);
    rst = 1'b1;
    beat(4, exp_re[4], exp_im[4]);
    rst = 1'b0;
    idle(4);
    chk("s6r_novalid", 64'(nv - nv0), 64'd0);
    chk("s6r_noerr", 64'(ne - ne0), 64'd0);
    chk("s6r_frame", {48'd0, frame_cnt}, 64'd0);
    chk("s6r_errcnt", {56'd0, err_cnt}, 64'd0);
    chk("s6r_bits", {48'd0, sym_bits}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
